// File: rtl/result_writeback_unit_pkg.sv
// Purpose: shared FSM encodings and BRAM write-mode constants for the result writeback unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package result_writeback_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_t;

    localparam logic WRITE_MODE_READ  = 1'b0;
    localparam logic WRITE_MODE_WRITE = 1'b1;

endpackage

// File: rtl/result_writeback_unit_fifo.sv
// Purpose: small synchronous FIFO buffering result words ahead of the BRAM port.
// Latency: a pushed word is visible at o_head the cycle after the push edge.
// Backpressure: o_full blocks pushes, o_empty blocks pops; guarded pushes/pops are dropped.
module wb_sync_fifo
    import result_writeback_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // Storage array: data only, pointers alone define validity so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/result_writeback_unit.sv
// Purpose: accepts a pass of 2**BRAM_DEPTH result words and writes them to BRAM addresses 0..N-1 in order.
// Latency: 2 cycles minimum from accept to the BRAM write strobe; 1 word/cycle sustained.
// Backpressure: res_ready drops when the FIFO is full or the pass quota is reached; bram_stall holds pops.
module result_writeback_unit
    import result_writeback_unit_pkg::*;
#(
    parameter int BRAM_DEPTH      = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  res_valid,
    input  logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_ready,
    input  logic                  bram_stall,
    output logic                  bram_en,
    output logic                  write_mode,
    output logic [BRAM_DEPTH-1:0] address,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    output logic                  busy,
    output logic                  done
);

    // Counters are one bit wider than the address so a full pass count is representable.
    localparam logic [BRAM_DEPTH:0] WORDS     = (BRAM_DEPTH + 1)'(1 << BRAM_DEPTH);
    localparam logic [BRAM_DEPTH:0] LAST_WORD = (BRAM_DEPTH + 1)'((1 << BRAM_DEPTH) - 1);

    wb_state_t             r_state;
    logic [BRAM_DEPTH:0]   r_acc_cnt;
    logic [BRAM_DEPTH:0]   r_wr_cnt;
    logic                  r_bram_en;
    logic                  r_write_mode;
    logic [BRAM_DEPTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_bram_wdata;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_fifo_head;
    logic                  w_push;
    logic                  w_pop;

    // Ready depends on registered state only, never on res_valid.
    assign res_ready = (r_state == ST_RUN) && !w_fifo_full && (r_acc_cnt < WORDS);
    assign w_push    = res_valid && res_ready;
    assign w_pop     = (r_state == ST_RUN) && !w_fifo_empty && !bram_stall;

    assign bram_en    = r_bram_en;
    assign write_mode = r_write_mode;
    assign address    = r_address;
    assign bram_wdata = r_bram_wdata;
    assign busy       = r_busy;
    assign done       = r_done;

    wb_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_data (res_data),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Pass FSM, accept/write counters and registered BRAM-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_acc_cnt    <= '0;
            r_wr_cnt     <= '0;
            r_bram_en    <= 1'b0;
            r_write_mode <= WRITE_MODE_READ;
            r_address    <= '0;
            r_bram_wdata <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // Default: no strobe this cycle; address and write data hold their last values.
            r_bram_en    <= 1'b0;
            r_write_mode <= WRITE_MODE_READ;
            if (w_push) begin
                r_acc_cnt <= r_acc_cnt + 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_acc_cnt <= '0;
                        r_wr_cnt  <= '0;
                        r_address <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored while a pass is running.
                    if (w_pop) begin
                        r_bram_en    <= 1'b1;
                        r_write_mode <= WRITE_MODE_WRITE;
                        r_address    <= r_wr_cnt[BRAM_DEPTH-1:0];
                        r_bram_wdata <= w_fifo_head;
                        r_wr_cnt     <= r_wr_cnt + 1'b1;
                        if (r_wr_cnt == LAST_WORD) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_writeback_unit.sv
// Purpose: directed table-driven and sequence checks of result_writeback_unit with default parameters.
// Latency: expectations are per-cycle, sampled 1-2 time units after the rising edge.
// Backpressure: exercised via bram_stall, FIFO full and excess res_valid beyond one pass.
module tb_result_writeback_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic        bram_stall;
    logic        bram_en;
    logic        write_mode;
    logic [1:0]  address;
    logic [31:0] bram_wdata;
    logic        busy;
    logic        done;

    result_writeback_unit #(
        .BRAM_DEPTH      (2),
        .DATA_WIDTH      (32),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .bram_stall (bram_stall),
        .bram_en    (bram_en),
        .write_mode (write_mode),
        .address    (address),
        .bram_wdata (bram_wdata),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        valid;
        logic [31:0] data;
        logic        ready;
        logic        en;
        logic        wm;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        busy;
        logic        done;
    } vec_t;

    localparam int NVEC = 27;
    vec_t tbl [NVEC];

    int          checks = 0;
    int          errors = 0;
    int          n_acc;
    logic [31:0] base;
    logic        last_ready;
    logic        pulsed;
    logic        s;
    logic [1:0]  cap_addr [$];
    logic [31:0] cap_data [$];

    function automatic vec_t mk(int st, int v, int d, int r, int e, int w, int a, int wd, int b, int dn);
        vec_t x;
        x.start = st[0];
        x.valid = v[0];
        x.data  = d;
        x.ready = r[0];
        x.en    = e[0];
        x.wm    = w[0];
        x.addr  = a[1:0];
        x.wdata = wd;
        x.busy  = b[0];
        x.done  = dn[0];
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample outputs mid-cycle, capture writes, advance past the edge.
    task automatic cycle(input logic st, input logic v, input logic stall);
        start      = st;
        res_valid  = v;
        res_data   = base + 32'(n_acc);
        bram_stall = stall;
        #1;
        last_ready = res_ready;
        if (bram_en === 1'b1) begin
            chk("wm_with_en", {31'd0, write_mode}, 32'd1);
            cap_addr.push_back(address);
            cap_data.push_back(bram_wdata);
        end
        if (v && res_ready) n_acc++;
        @(posedge clk);
        #1;
        start     = 1'b0;
        res_valid = 1'b0;
    endtask

    task automatic check_pass(input string tag, input logic [31:0] b);
        chk({tag, "_nwrites"}, 32'(cap_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap_addr.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), {30'd0, cap_addr[i]}, 32'(i));
                chk($sformatf("%s_data%0d", tag, i), cap_data[i], b + 32'(i));
            end
        end
        cap_addr.delete();
        cap_data.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, res_ready}, 32'd0);
        chk({tag, "_en"},    {31'd0, bram_en},   32'd0);
        chk({tag, "_wm"},    {31'd0, write_mode}, 32'd0);
        chk({tag, "_addr"},  {30'd0, address},   32'd0);
        chk({tag, "_wdata"}, bram_wdata,         32'd0);
        chk({tag, "_busy"},  {31'd0, busy},      32'd0);
        chk({tag, "_done"},  {31'd0, done},      32'd0);
    endtask

    initial begin
        // Fields: start valid data | ready en wm addr wdata busy done (outputs seen during that cycle)
        tbl[0]  = mk(1, 0, 0,     0, 0, 0, 0, 0,     0, 0);
        tbl[1]  = mk(0, 1, 'hA0,  1, 0, 0, 0, 0,     1, 0);
        tbl[2]  = mk(0, 1, 'hA1,  1, 0, 0, 0, 0,     1, 0);
        tbl[3]  = mk(0, 1, 'hA2,  1, 1, 1, 0, 'hA0,  1, 0);
        tbl[4]  = mk(0, 1, 'hA3,  1, 1, 1, 1, 'hA1,  1, 0);
        tbl[5]  = mk(0, 0, 0,     0, 1, 1, 2, 'hA2,  1, 0);
        tbl[6]  = mk(0, 0, 0,     0, 1, 1, 3, 'hA3,  0, 1);
        tbl[7]  = mk(0, 0, 0,     0, 0, 0, 3, 'hA3,  0, 1);
        tbl[8]  = mk(1, 0, 0,     0, 0, 0, 3, 'hA3,  0, 1);
        tbl[9]  = mk(0, 1, 'hB0,  1, 0, 0, 0, 'hA3,  1, 0);
        tbl[10] = mk(0, 1, 'hB1,  1, 0, 0, 0, 'hA3,  1, 0);
        tbl[11] = mk(0, 1, 'hB2,  1, 1, 1, 0, 'hB0,  1, 0);
        tbl[12] = mk(0, 1, 'hB3,  1, 1, 1, 1, 'hB1,  1, 0);
        tbl[13] = mk(0, 1, 'hB4,  0, 1, 1, 2, 'hB2,  1, 0);
        tbl[14] = mk(0, 1, 'hB5,  0, 1, 1, 3, 'hB3,  0, 1);
        tbl[15] = mk(0, 0, 0,     0, 0, 0, 3, 'hB3,  0, 1);
        tbl[16] = mk(1, 0, 0,     0, 0, 0, 3, 'hB3,  0, 1);
        tbl[17] = mk(0, 1, 'hC0,  1, 0, 0, 0, 'hB3,  1, 0);
        tbl[18] = mk(0, 0, 0,     1, 0, 0, 0, 'hB3,  1, 0);
        tbl[19] = mk(0, 1, 'hC1,  1, 1, 1, 0, 'hC0,  1, 0);
        tbl[20] = mk(0, 0, 0,     1, 0, 0, 0, 'hC0,  1, 0);
        tbl[21] = mk(0, 1, 'hC2,  1, 1, 1, 1, 'hC1,  1, 0);
        tbl[22] = mk(0, 0, 0,     1, 0, 0, 1, 'hC1,  1, 0);
        tbl[23] = mk(0, 1, 'hC3,  1, 1, 1, 2, 'hC2,  1, 0);
        tbl[24] = mk(0, 0, 0,     0, 0, 0, 2, 'hC2,  1, 0);
        tbl[25] = mk(0, 0, 0,     0, 1, 1, 3, 'hC3,  0, 1);
        tbl[26] = mk(0, 0, 0,     0, 0, 0, 3, 'hC3,  0, 1);

        reset_n    = 1'b0;
        start      = 1'b0;
        res_valid  = 1'b0;
        res_data   = '0;
        bram_stall = 1'b0;
        n_acc      = 0;
        base       = '0;
        last_ready = 1'b0;
        pulsed     = 1'b0;
        #12;
        check_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Full pass, excess-valid pass, start-from-DONE and alternating-valid pass.
        for (int i = 0; i < NVEC; i++) begin
            start      = tbl[i].start;
            res_valid  = tbl[i].valid;
            res_data   = tbl[i].data;
            bram_stall = 1'b0;
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, res_ready},  {31'd0, tbl[i].ready});
            chk($sformatf("v%0d_en", i),    {31'd0, bram_en},    {31'd0, tbl[i].en});
            chk($sformatf("v%0d_wm", i),    {31'd0, write_mode}, {31'd0, tbl[i].wm});
            chk($sformatf("v%0d_addr", i),  {30'd0, address},    {30'd0, tbl[i].addr});
            chk($sformatf("v%0d_wdata", i), bram_wdata,          tbl[i].wdata);
            chk($sformatf("v%0d_busy", i),  {31'd0, busy},       {31'd0, tbl[i].busy});
            chk($sformatf("v%0d_done", i),  {31'd0, done},       {31'd0, tbl[i].done});
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        res_valid = 1'b0;

        // Stall from pass start: FIFO fills after 4 accepts, then drains in order.
        n_acc = 0;
        base  = 32'h30;
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b1);
            if (i >= 4) chk($sformatf("stall_ready_c%0d", i), {31'd0, last_ready}, 32'd0);
        end
        chk("stall_nowrite", 32'(cap_addr.size()), 32'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("stall_accepts", 32'(n_acc), 32'd4);
        check_pass("stall", 32'h30);
        chk("stall_done", {31'd0, done}, 32'd1);

        // start pulsed in RUN right after the 2nd write must be ignored.
        n_acc  = 0;
        base   = 32'h50;
        pulsed = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            s = (cap_addr.size() == 2) && !pulsed;
            if (s) pulsed = 1'b1;
            cycle(s, 1'b1, 1'b0);
        end
        chk("run_start_pulsed", {31'd0, pulsed}, 32'd1);
        chk("run_start_accepts", 32'(n_acc), 32'd4);
        check_pass("runstart", 32'h50);
        chk("runstart_done", {31'd0, done}, 32'd1);

        // start in DONE clears done and begins a new pass at address 0.
        n_acc = 0;
        base  = 32'h60;
        cycle(1'b1, 1'b0, 1'b0);
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_addr", {30'd0, address}, 32'd0);

        // Reset mid-pass after 2 writes: everything clears immediately.
        for (int i = 0; i < 10; i++) begin
            if (cap_addr.size() < 2) cycle(1'b0, 1'b1, 1'b0);
        end
        chk("midrst_nwrites", 32'(cap_addr.size()), 32'd2);
        if (cap_addr.size() >= 2) begin
            chk("midrst_d0", cap_data[0], 32'h60);
            chk("midrst_d1", cap_data[1], 32'h61);
        end
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        cap_addr.delete();
        cap_data.delete();
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_acc = 0;
        base  = 32'h70;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
        check_pass("postrst", 32'h70);
        chk("postrst_done", {31'd0, done}, 32'd1);
        chk("postrst_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
